// File: rtl/lfsr_decrypt_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_decrypt_pkg
// Shared definitions for the LFSR decryption sequencer:
//   - TAP_TABLE  : the nine candidate 7-bit feedback tap patterns, index 0..8
//   - state_e    : sequencer FSM states
//   - SPACE_CHAR : the known preamble character used to identify the tap/seed
//   - lfsr_step  : one shift of the 7-bit Fibonacci LFSR
// -----------------------------------------------------------------------------
package lfsr_decrypt_pkg;

  localparam int NUM_TAPS = 9;

  // Packed so that TAP_TABLE[k] is entry k (entry 0 is the rightmost element).
  localparam logic [NUM_TAPS-1:0][6:0] TAP_TABLE = {
    7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
  };

  localparam logic [7:0] SPACE_CHAR = 8'h20;
  localparam logic [6:0] SPACE7     = SPACE_CHAR[6:0];

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SEED,
    CHECK,
    DECRYPT_RD,
    DECRYPT_WR,
    DONE
  } state_e;

  // Shift left, feeding back the parity of the tapped bits into bit 0.
  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
    return {s[5:0], ^(s & tap)};
  endfunction

endpackage

// File: rtl/lfsr_decrypt_seq_if.sv
// -----------------------------------------------------------------------------
// lfsr_decrypt_seq_if
// Bundles the start/complete handshake and the data-memory port of the
// decryption sequencer.
//   req         : start request (host -> sequencer)
//   ack/err     : run complete / no tap pattern matched
//   pat_idx     : matched tap index, valid with ack
//   dm_addr     : data memory address
//   dm_rd_data  : synchronous read data, one cycle after dm_addr
//   dm_wr_en    : write strobe, dm_wr_data : write data
//   par_err_cnt : ciphertext parity-failure count (zero unless enabled)
// Modports: master = sequencer side, slave = host/memory side.
// -----------------------------------------------------------------------------
interface lfsr_decrypt_seq_if #(
  parameter int AW = 8
);
  logic          req;
  logic          ack;
  logic          err;
  logic [3:0]    pat_idx;
  logic [AW-1:0] dm_addr;
  logic [7:0]    dm_rd_data;
  logic          dm_wr_en;
  logic [7:0]    dm_wr_data;
  logic [6:0]    par_err_cnt;

  modport master (
    input  req, dm_rd_data,
    output ack, err, pat_idx, dm_addr, dm_wr_en, dm_wr_data, par_err_cnt
  );

  modport slave (
    output req, dm_rd_data,
    input  ack, err, pat_idx, dm_addr, dm_wr_en, dm_wr_data, par_err_cnt
  );
endinterface

// File: rtl/lfsr_decrypt_seq_lfsr7.sv
// -----------------------------------------------------------------------------
// lfsr7_reg
// 7-bit LFSR state register shared by the tap search and the decrypt phase.
//   clk, rst_n : clock, asynchronous active-low reset (state clears to 0)
//   load, seed : load the seed value (has priority over step)
//   step, tap  : advance one LFSR step with the given tap pattern
//   state      : current register contents
// -----------------------------------------------------------------------------
module lfsr7_reg
  import lfsr_decrypt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [6:0] seed,
  input  logic [6:0] tap,
  output logic [6:0] state
);

  logic [6:0] state_q;
  logic [6:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = lfsr_step(state_q, tap);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_decrypt_seq.sv
// -----------------------------------------------------------------------------
// lfsr_decrypt_seq
// Decrypts MSG_LEN parity-tagged ciphertext bytes at CIPHER_BASE into
// plaintext at PLAIN_BASE. The tap pattern and start state are found by
// requiring the first PRE_CHECK bytes to decrypt to spaces; the lowest
// matching tap index wins.
// Ports:
//   clk    : system clock, rising edge
//   init_n : asynchronous active-low reset
//   bus    : lfsr_decrypt_seq_if.master (req/ack/err/pat_idx, memory port,
//            par_err_cnt)
// Memory timing: the address driven in cycle t is returned on dm_rd_data in
// cycle t+1. Each state therefore drives the address that the following
// state consumes; dm_addr/dm_wr_en/dm_wr_data are decoded from the state
// registers (and, in CHECK, from the compare result).
// Optional build macro: LFSR_DECRYPT_PARITY_CHK_EN enables the parity-failure
// counter; without it par_err_cnt is tied to zero.
// -----------------------------------------------------------------------------
module lfsr_decrypt_seq
  import lfsr_decrypt_pkg::*;
#(
  parameter int CIPHER_BASE = 64,
  parameter int PLAIN_BASE  = 0,
  parameter int MSG_LEN     = 64,
  parameter int PRE_CHECK   = 10,
  parameter int AW          = 8
) (
  input  logic               clk,
  input  logic               init_n,
  lfsr_decrypt_seq_if.master bus
);

  localparam logic [AW-1:0] CIPHER_A = AW'(CIPHER_BASE);
  localparam logic [AW-1:0] PLAIN_A  = AW'(PLAIN_BASE);
  localparam logic [6:0]    PRE_LAST = 7'(PRE_CHECK - 1);
  localparam logic [6:0]    MSG_LAST = 7'(MSG_LEN - 1);
  localparam logic [3:0]    LAST_PAT = 4'(NUM_TAPS - 1);

  state_e     state_q, state_d;
  logic [3:0] p_q, p_d;
  logic [6:0] i_q, i_d;
  logic [6:0] j_q, j_d;
  logic [6:0] seed_q, seed_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic [3:0] pat_idx_q, pat_idx_d;

  logic [6:0]    s_cur;
  logic [6:0]    s_adv;
  logic [6:0]    tap_sel;
  logic          s_load;
  logic          s_step;
  logic [6:0]    s_load_val;
  logic [6:0]    rd7;
  logic [AW-1:0] addr_c;
  logic          wr_en_c;
  logic [7:0]    wr_data_c;

  // p_q keeps the matched index through the decrypt phase, so one tap mux
  // serves both phases.
  assign tap_sel = TAP_TABLE[p_q];
  assign s_adv   = lfsr_step(s_cur, tap_sel);
  // Bit 7 is parity only and never enters the decryption.
  assign rd7     = bus.dm_rd_data[6:0];

  lfsr7_reg u_lfsr (
    .clk   (clk),
    .rst_n (init_n),
    .load  (s_load),
    .step  (s_step),
    .seed  (s_load_val),
    .tap   (tap_sel),
    .state (s_cur)
  );

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    i_d        = i_q;
    j_d        = j_q;
    seed_d     = seed_q;
    ack_d      = ack_q;
    err_d      = err_q;
    pat_idx_d  = pat_idx_q;
    s_load     = 1'b0;
    s_step     = 1'b0;
    s_load_val = seed_q;
    addr_c     = '0;
    wr_en_c    = 1'b0;
    wr_data_c  = '0;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        // Prefetch byte 0 so SEED sees it on dm_rd_data.
        addr_c = CIPHER_A;
        if (!bus.req) begin
          p_d     = '0;
          state_d = SEED;
        end
      end

      SEED: begin
        // Byte 0 decrypts to a space, so its key is the LFSR start state.
        seed_d     = rd7 ^ SPACE7;
        s_load     = 1'b1;
        s_load_val = rd7 ^ SPACE7;
        i_d        = 7'd1;
        addr_c     = CIPHER_A + AW'(1);
        state_d    = CHECK;
      end

      CHECK: begin
        if ((rd7 ^ s_adv) == SPACE7) begin
          if (i_q == PRE_LAST) begin
            // Whole preamble matched: rewind to byte 0 for decryption.
            pat_idx_d  = p_q;
            s_load     = 1'b1;
            s_load_val = seed_q;
            j_d        = '0;
            state_d    = DECRYPT_RD;
          end else begin
            s_step  = 1'b1;
            i_d     = i_q + 7'd1;
            addr_c  = CIPHER_A + AW'(i_q + 7'd1);
          end
        end else begin
          // Refetch byte 0 for the next candidate's SEED cycle.
          addr_c = CIPHER_A;
          if (p_q == LAST_PAT) begin
            err_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = DONE;
          end else begin
            p_d     = p_q + 4'd1;
            state_d = SEED;
          end
        end
      end

      DECRYPT_RD: begin
        addr_c  = CIPHER_A + AW'(j_q);
        state_d = DECRYPT_WR;
      end

      DECRYPT_WR: begin
        wr_en_c   = 1'b1;
        addr_c    = PLAIN_A + AW'(j_q);
        wr_data_c = {1'b0, rd7 ^ s_cur};
        s_step    = 1'b1;
        if (j_q == MSG_LAST) begin
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          j_d     = j_q + 7'd1;
          state_d = DECRYPT_RD;
        end
      end

      DONE: begin
        if (bus.req) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ARMED;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= IDLE;
      p_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      seed_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      pat_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      i_q       <= i_d;
      j_q       <= j_d;
      seed_q    <= seed_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      pat_idx_q <= pat_idx_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
  assign bus.pat_idx    = pat_idx_q;
  assign bus.dm_addr    = addr_c;
  assign bus.dm_wr_en   = wr_en_c;
  assign bus.dm_wr_data = wr_data_c;

`ifdef LFSR_DECRYPT_PARITY_CHK_EN
  logic [6:0] par_cnt_q, par_cnt_d;

  // DECRYPT_WR is the cycle in which the byte fetched by DECRYPT_RD is
  // visible, so the parity test lives there. Even parity: bit 7 must equal
  // the XOR of bits 6:0.
  always_comb begin
    par_cnt_d = par_cnt_q;
    if (state_q == ARMED && !bus.req) begin
      par_cnt_d = '0;
    end else if (state_q == DECRYPT_WR &&
                 (bus.dm_rd_data[7] != ^bus.dm_rd_data[6:0]) &&
                 par_cnt_q != 7'h7F) begin
      par_cnt_d = par_cnt_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      par_cnt_q <= '0;
    end else begin
      par_cnt_q <= par_cnt_d;
    end
  end

  assign bus.par_err_cnt = par_cnt_q;
`else
  // Parity bit has no consumer in this build.
  logic unused_parity_bit;
  assign unused_parity_bit = bus.dm_rd_data[7];
  assign bus.par_err_cnt   = '0;
`endif

endmodule

// File: doc/lfsr_decrypt_seq.md
Name: lfsr_decrypt_seq

Overview:
Hardware sequencer that runs the Program 2 decryption in place of the instruction-driven core. It reads the 64 parity-tagged ciphertext bytes at data_mem[64..127] and identifies the LFSR tap pattern and start state from the known space preamble. It then writes the 64 decrypted bytes to data_mem[0..63]. It sits beside top_level's data memory, owns the memory port while busy, and reports completion on the req/ack handshake.

Parameters:
CIPHER_BASE, 64, first ciphertext address
PLAIN_BASE, 0, first plaintext address
MSG_LEN, 64, bytes decrypted per run
PRE_CHECK, 10, leading bytes that must decrypt to 0x20 for a tap pattern to match
AW, 8, data memory address width

Ports:
clk  in  1  system clock, rising edge
init_n  in  1  reset, asynchronous, active-low
req  in  1  start request; run launches when req falls after being high
ack  out  1  run complete, held until next req rise
err  out  1  valid with ack; no tap pattern matched the preamble
pat_idx  out  4  valid with ack; index 0..8 of the matched tap pattern
dm_addr  out  AW  data memory address
dm_rd_data  in  8  read data, synchronous, 1-cycle latency
dm_wr_en  out  1  write strobe
dm_wr_data  out  8  write data
par_err_cnt  out  7  parity-failure count (macro-dependent)

Behaviour:
- Reset (init_n=0, asynchronous, any state): state=IDLE; ack, err, dm_wr_en=0; pat_idx, dm_addr, dm_wr_data, par_err_cnt=0. A reset mid-run abandons it; bytes already written stay written.
- Tap table, indices 0..8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- LFSR step: s_next = {s[5:0], ^(s & tap)}.
- States: IDLE, ARMED, SEED, CHECK, DECRYPT_RD, DECRYPT_WR, DONE.
- IDLE: on req=1, go to ARMED.
- ARMED: on req=0, go to SEED with p=0.
- SEED: read addr CIPHER_BASE; s = rd[6:0] ^ 7'h20. Then go to CHECK with i=1.
- CHECK: step s; read CIPHER_BASE+i; compare rd[6:0]^s against 7'h20.
  - Mismatch: p++ and return to SEED. If p was 8, go to DONE with err=1 and no writes.
  - Match: i++. If i reaches PRE_CHECK, the pattern is found: pat_idx=p, and s is reloaded to the seed for byte 0.
  - Lowest matching index wins.
- DECRYPT: two cycles per byte, since the memory is single-port.
  - DECRYPT_RD drives CIPHER_BASE+j.
  - DECRYPT_WR drives dm_wr_en=1, dm_addr=PLAIN_BASE+j, dm_wr_data={1'b0, rd[6:0]^s}, then steps s and increments j.
  - After j=MSG_LEN-1, go to DONE.
  - Phase length is exactly 2*MSG_LEN cycles.
- dm_wr_en is asserted only in DECRYPT_WR. Ciphertext bit 7 (parity) is never used in decryption.
- DONE: ack=1; err and pat_idx are held. On req=1, clear ack and err and go to ARMED.
- Address arithmetic is AW bits and wraps modulo 2^AW. Counters i and j are 7-bit.
- req toggling while busy is ignored.

Optional Feature:
- Macro LFSR_DECRYPT_PARITY_CHK_EN.
- When defined: in DECRYPT_RD capture, each byte with rd[7] != ^rd[6:0] increments par_err_cnt, saturating at 127. The count clears on leaving ARMED and is held through DONE. Decryption output is unaffected.
- When undefined: par_err_cnt is constant 0 and no parity logic is synthesized.

Decomposition:
- Package lfsr_decrypt_pkg: the 9-entry tap table constant, the state enum typedef, SPACE_CHAR=8'h20, and the lfsr_step function.
- One sub-module, lfsr7_reg: 7-bit state register with load (seed value) and step (tap input) controls, plus a current-state output. It is used for both the search and decrypt phases.

Test Plan:
- Encrypt "Knowledge comes, but wisdom lingers" with tap 0x6A, init 0x01, pre_length 10 -> ack=1, err=0, pat_idx=4, dm[0..9]=0x20, dm[10]=0x4B, all 64 bytes match the bench.
- Repeat with tap 0x60 and tap 0x7B, random nonzero init -> pat_idx=0 and 8 respectively, 64/64 correct.
- Corrupt ciphertext byte 5 so no pattern survives -> err=1 after the search; dm[0..63] is untouched.
- Assert init_n=0 while j=20, then release and rerun -> outputs reset immediately; second run gives 64/64 correct.
- Hold req=1 after DONE -> ack drops the cycle after req rises; a new run starts on the req fall.
- With the macro defined, flip bit 7 of cipher bytes 70 and 100 -> par_err_cnt=2 and plaintext is still 64/64 correct. Without the macro -> par_err_cnt=0.
